// File: rtl/core_pkg.sv
// Shared core definitions: write-back source selects and architectural register constants.
package core_pkg;

  typedef enum logic [1:0] {
    WB_SEL_ALU = 2'd0,
    WB_SEL_MEM = 2'd1,
    WB_SEL_PC4 = 2'd2,
    WB_SEL_IMM = 2'd3
  } wb_sel_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_regfile_hazard_regfile_2r1w.sv
// Two-read one-write register file with x0 hardwired to zero and write-back bypass on reads.
module regfile_2r1w
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != REG_ZERO) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Bypass makes a same-cycle write visible to decode without waiting a cycle.
  always_comb begin
    rd1 = '0;
    if (rs1 != REG_ZERO) rd1 = (wb_we && wb_rd == rs1) ? wb_data : regs[rs1];
  end

  always_comb begin
    rd2 = '0;
    if (rs2 != REG_ZERO) rd2 = (wb_we && wb_rd == rs2) ? wb_data : regs[rs2];
  end

endmodule

// File: rtl/id_regfile_hazard.sv
// Decode-stage register file plus load-use / redirect hazard control and saturating perf counters.
module id_regfile_hazard
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_reg_write,
  input  logic [1:0]       i_ex_sel_wb,
  input  logic             i_ex_redirect,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_wb_reg_write,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic [XLEN-1:0]  o_id_rd1,
  output logic [XLEN-1:0]  o_id_rd2,
  output logic             o_stall_pc,
  output logic             o_stall_ifid,
  output logic             o_flush_ifid,
  output logic             o_bubble_idex,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic            load_use;
  logic            stall_ev;
  logic            flush_ev;

  regfile_2r1w #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .resetn  (resetn),
    .rs1     (i_id_rs1),
    .rs2     (i_id_rs2),
    .wb_rd   (i_wb_rd),
    .wb_we   (i_wb_reg_write),
    .wb_data (i_wb_data),
    .rd1     (rf_rd1),
    .rd2     (rf_rd2)
  );

  // Reads are gated by reset so a live bypass cannot leak data while held in reset.
  assign o_id_rd1 = resetn ? rf_rd1 : '0;
  assign o_id_rd2 = resetn ? rf_rd2 : '0;

  always_comb begin
    load_use = i_ex_reg_write && (wb_sel_e'(i_ex_sel_wb) == WB_SEL_MEM) && (i_ex_rd != REG_ZERO)
            && ((i_id_use_rs1 && i_ex_rd == i_id_rs1) || (i_id_use_rs2 && i_ex_rd == i_id_rs2));
  end

  // Redirect squashes the decode instruction, so any load-use against it is moot.
  assign flush_ev = i_ex_redirect;
  assign stall_ev = load_use && !i_ex_redirect;

  always_comb begin
    o_stall_pc    = 1'b0;
    o_stall_ifid  = 1'b0;
    o_flush_ifid  = 1'b0;
    o_bubble_idex = 1'b0;
    if (resetn) begin
      o_stall_pc    = stall_ev;
      o_stall_ifid  = stall_ev;
      o_flush_ifid  = flush_ev;
      o_bubble_idex = stall_ev || flush_ev;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (stall_ev && o_stall_cnt != '1) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      if (flush_ev && o_flush_cnt != '1) o_flush_cnt <= o_flush_cnt + CNT_W'(1);
    end
  end

endmodule
